// File: rtl/text_console.sv
// Character-cell text console: a writer FSM places characters, scrolls and clears a
// COLS x ROWS cell buffer, while an independent registered port reads cells for display.
module text_console #(
   parameter int COLS         = 80,
   parameter int ROWS         = 30,
   parameter int ATTR_W       = 6,
   parameter int BLINK_CYCLES = 25000000,
   localparam int CW = $clog2(COLS),
   localparam int RW = $clog2(ROWS)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   input  logic [7:0]        in_char,
   input  logic [ATTR_W-1:0] in_attr,
   output logic              in_ready,
   input  logic [CW-1:0]     rd_col,
   input  logic [RW-1:0]     rd_row,
   output logic [7:0]        rd_char,
   output logic [ATTR_W-1:0] rd_attr,
   output logic              rd_cursor,
   output logic [CW-1:0]     cur_col,
   output logic [RW-1:0]     cur_row,
   output logic              busy,
   output logic [1:0]        fsm_state
);

   localparam int N      = COLS * ROWS;
   localparam int AW     = (N > 1) ? $clog2(N) : 1;
   localparam int COPY_N = (ROWS - 1) * COLS;
   localparam int CELL_W = 8 + ATTR_W;
   localparam int BW     = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [CELL_W-1:0] BLANK = {8'h20, {ATTR_W{1'b0}}};

   // Handshake: a character is taken on a rising edge where in_valid && in_ready;
   // the source keeps in_char/in_attr stable until then. in_ready is high only in IDLE.
   typedef enum logic [1:0] {CLEAR, IDLE, SCROLL_COPY, SCROLL_FILL} state_t;

   state_t            state, state_next;
   logic [AW-1:0]     pos;
   logic [CELL_W-1:0] mem [N];
   logic              we;
   logic [AW-1:0]     waddr;
   logic [CELL_W-1:0] wdata;
   logic              accept, printable, is_cr, is_lf, is_bs, is_clr;
   logic              at_last_col, at_last_row, row_adv;
   logic [AW-1:0]     cur_addr;
   logic [BW-1:0]     blink_cnt;
   logic              blink_on;
   logic              rd_in_range;
   logic [AW-1:0]     rd_addr;

   assign accept      = in_valid && in_ready;
   assign printable   = (in_char >= 8'h20) && (in_char <= 8'hBA);
   assign is_cr       = (in_char == 8'h0D);
   assign is_lf       = (in_char == 8'h0A);
   assign is_bs       = (in_char == 8'h08);
   assign is_clr      = (in_char == 8'h00) || (in_char == 8'h0C);
   assign at_last_col = (cur_col == CW'(COLS - 1));
   assign at_last_row = (cur_row == RW'(ROWS - 1));
   assign row_adv     = (printable && at_last_col) || is_lf;
   assign cur_addr    = AW'(cur_row) * AW'(COLS) + AW'(cur_col);
   assign fsm_state   = state;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= CLEAR;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         CLEAR:       if (pos == AW'(N - 1)) state_next = IDLE;
         IDLE: begin
            if (accept) begin
               if (is_clr)                      state_next = CLEAR;
               else if (row_adv && at_last_row) state_next = (COPY_N > 0) ? SCROLL_COPY : SCROLL_FILL;
            end
         end
         SCROLL_COPY: if (pos == AW'(COPY_N - 1)) state_next = SCROLL_FILL;
         SCROLL_FILL: if (pos == AW'(N - 1)) state_next = IDLE;
         default:     state_next = CLEAR;
      endcase
   end

   // Copy walks upward, so the source row below is always still pre-scroll content.
   always_comb begin
      in_ready = (state == IDLE);
      busy     = (state != IDLE);
      we       = 1'b0;
      waddr    = pos;
      wdata    = BLANK;
      case (state)
         CLEAR, SCROLL_FILL: we = 1'b1;
         SCROLL_COPY: begin
            we    = 1'b1;
            wdata = mem[pos + AW'(COLS)];
         end
         IDLE: begin
            if (in_valid) begin
               if (printable) begin
                  we    = 1'b1;
                  waddr = cur_addr;
                  wdata = {in_char, in_attr};
               end else if (is_bs && (cur_col != '0)) begin
                  we    = 1'b1;
                  waddr = cur_addr - AW'(1);
               end
            end
         end
         default: ;
      endcase
   end

   // One cell per busy cycle; the copy-to-fill handoff continues the same count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                pos <= '0;
      else if (state == IDLE || state_next == IDLE) pos <= '0;
      else                                         pos <= pos + AW'(1);
   end

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur_col <= '0;
         cur_row <= '0;
      end else if (accept) begin
         if (is_clr) begin
            cur_col <= '0;
            cur_row <= '0;
         end else if (printable) begin
            if (at_last_col) begin
               cur_col <= '0;
               if (!at_last_row) cur_row <= cur_row + RW'(1);
            end else begin
               cur_col <= cur_col + CW'(1);
            end
         end else if (is_cr) begin
            cur_col <= '0;
         end else if (is_lf) begin
            cur_col <= '0;
            if (!at_last_row) cur_row <= cur_row + RW'(1);
         end else if (is_bs && (cur_col != '0)) begin
            cur_col <= cur_col - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else if (accept) begin
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
         blink_cnt <= '0;
         blink_on  <= !blink_on;
      end else begin
         blink_cnt <= blink_cnt + BW'(1);
      end
   end

   assign rd_in_range = (32'(rd_col) < COLS) && (32'(rd_row) < ROWS);
   assign rd_addr     = AW'(rd_row) * AW'(COLS) + AW'(rd_col);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_char   <= 8'h20;
         rd_attr   <= '0;
         rd_cursor <= 1'b0;
      end else if (rd_in_range) begin
         {rd_char, rd_attr} <= mem[rd_addr];
         rd_cursor          <= blink_on && (rd_col == cur_col) && (rd_row == cur_row);
      end else begin
         rd_char   <= 8'h20;
         rd_attr   <= '0;
         rd_cursor <= 1'b0;
      end
   end

endmodule
